// File: rtl/btn_cnt_ctrl_if.sv
// Button/switch inputs and command bus of the up/down counter controller.
interface btn_cnt_ctrl_if;
  logic       BTN_UP;
  logic       BTN_DN;
  logic       BTN_LD;
  logic [3:0] SW;
  logic [3:0] D;
  logic       LD;
  logic       UD;
  logic       CE;

  modport master (
    input  BTN_UP, BTN_DN, BTN_LD, SW,
    output D, LD, UD, CE
  );

  modport slave (
    output BTN_UP, BTN_DN, BTN_LD, SW,
    input  D, LD, UD, CE
  );
endinterface

// File: rtl/btn_cnt_ctrl.sv
// Debounced push-button front end for an up/down counter: synchronizes, debounces,
// prioritises LD > UP > DN and auto-repeats a held UP/DN button.
module btn_cnt_ctrl #(
  parameter int unsigned DB_CYCLES  = 250000,
  parameter int unsigned RPT_DELAY  = 50000000,
  parameter int unsigned RPT_PERIOD = 10000000
) (
  input logic            CLK,
  input logic            RST,
  btn_cnt_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RPT = 2'd2} state_t;

  localparam logic [25:0] DB_C  = 26'(DB_CYCLES);
  localparam logic [26:0] DLY_C = 27'(RPT_DELAY);
  localparam logic [26:0] PER_C = 27'(RPT_PERIOD);

  logic [2:0]  btn_meta_r, btn_sync_r, btn_lvl_r;
  logic [3:0]  sw_meta_r, sw_sync_r;
  logic [25:0] db_cnt_r [3];
  logic [2:0]  press_s;
  logic        press_ld_s, press_up_s, press_dn_s, dir_lvl_s, tick_s;
  logic [26:0] timer_inc_s;
  state_t      state_r, state_nxt;
  logic [25:0] timer_r, timer_nxt;
  logic        dir_r, dir_nxt;
  logic        ce_r, ld_r, ud_r, ce_nxt, ld_nxt, ud_nxt;
  logic [3:0]  d_r, d_nxt;

  // Two-flop synchronizers; bit 0 = UP, bit 1 = DN, bit 2 = LD.
  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_meta_r <= 3'b000;
      btn_sync_r <= 3'b000;
      sw_meta_r  <= 4'h0;
      sw_sync_r  <= 4'h0;
    end else begin
      btn_meta_r <= {bus.BTN_LD, bus.BTN_DN, bus.BTN_UP};
      btn_sync_r <= btn_meta_r;
      sw_meta_r  <= bus.SW;
      sw_sync_r  <= sw_meta_r;
    end
  end

  // Debounce counters: count disagreeing cycles, adopt the synced level at DB_CYCLES.
  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_lvl_r <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_r[i] <= 26'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (btn_sync_r[i] == btn_lvl_r[i]) begin
          db_cnt_r[i] <= 26'd0;
        end else if (db_cnt_r[i] == DB_C) begin
          btn_lvl_r[i] <= btn_sync_r[i];
          db_cnt_r[i] <= 26'd0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + 26'd1;
        end
      end
    end
  end

  // Press detection on the debounced rising edge, then priority resolution.
  always_comb begin
    press_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      press_s[i] = (db_cnt_r[i] == DB_C) && btn_sync_r[i] && !btn_lvl_r[i];
    end
    press_ld_s = press_s[2];
    press_up_s = press_s[0] && !press_s[2];
    press_dn_s = press_s[1] && !press_s[2] && !press_s[0];
  end

  // Repeat FSM state, timer and direction registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      timer_r <= 26'd0;
      dir_r   <= 1'b1;
    end else begin
      state_r <= state_nxt;
      timer_r <= timer_nxt;
      dir_r   <= dir_nxt;
    end
  end

  // Next state: a press restarts WAIT; the timer reload happens on the edge it would reach the limit.
  always_comb begin
    state_nxt   = state_r;
    timer_nxt   = timer_r;
    dir_nxt     = dir_r;
    tick_s      = 1'b0;
    timer_inc_s = {1'b0, timer_r} + 27'd1;
    dir_lvl_s   = dir_r ? btn_lvl_r[0] : btn_lvl_r[1];
    if (press_up_s || press_dn_s) begin
      state_nxt = WAIT;
      timer_nxt = 26'd0;
      dir_nxt   = press_up_s;
    end else begin
      case (state_r)
        IDLE: begin
          timer_nxt = 26'd0;
        end
        WAIT: begin
          if (!dir_lvl_s) begin
            state_nxt = IDLE;
            timer_nxt = 26'd0;
          end else if (timer_inc_s == DLY_C) begin
            state_nxt = RPT;
            timer_nxt = 26'd0;
            tick_s    = 1'b1;
          end else begin
            timer_nxt = timer_inc_s[25:0];
          end
        end
        RPT: begin
          if (!dir_lvl_s) begin
            state_nxt = IDLE;
            timer_nxt = 26'd0;
          end else if (timer_inc_s == PER_C) begin
            timer_nxt = 26'd0;
            tick_s    = 1'b1;
          end else begin
            timer_nxt = timer_inc_s[25:0];
          end
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = 26'd0;
        end
      endcase
    end
  end

  // Command outputs: a press always wins over a coincident repeat tick.
  always_comb begin
    ce_nxt = 1'b0;
    ld_nxt = 1'b0;
    ud_nxt = ud_r;
    d_nxt  = d_r;
    if (press_ld_s) begin
      ce_nxt = 1'b1;
      ld_nxt = 1'b1;
      d_nxt  = sw_sync_r;
    end else if (press_up_s) begin
      ce_nxt = 1'b1;
      ud_nxt = 1'b1;
    end else if (press_dn_s) begin
      ce_nxt = 1'b1;
      ud_nxt = 1'b0;
    end else if (tick_s) begin
      ce_nxt = 1'b1;
      ud_nxt = dir_r;
    end else begin
      ce_nxt = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ce_r <= 1'b0;
      ld_r <= 1'b0;
      ud_r <= 1'b1;
      d_r  <= 4'h0;
    end else begin
      ce_r <= ce_nxt;
      ld_r <= ld_nxt;
      ud_r <= ud_nxt;
      d_r  <= d_nxt;
    end
  end

  assign bus.CE = ce_r;
  assign bus.LD = ld_r;
  assign bus.UD = ud_r;
  assign bus.D  = d_r;

endmodule

// File: tb/tb_btn_cnt_ctrl.sv
// Directed bench for btn_cnt_ctrl with DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=5.
module tb_btn_cnt_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  int         n_chk = 0;
  int         n_err = 0;
  logic       ud_m;
  logic [3:0] d_m;
  logic       exp_ce;
  logic       exp_ld;

  btn_cnt_ctrl_if bus ();

  btn_cnt_ctrl #(.DB_CYCLES(4), .RPT_DELAY(20), .RPT_PERIOD(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_outs(input string tag, input int e);
    string t;
    t = $sformatf("%s@%0d", tag, e);
    chk_eq({t, ".ce"}, 32'(bus.CE), 32'(exp_ce));
    chk_eq({t, ".ld"}, 32'(bus.LD), 32'(exp_ld));
    chk_eq({t, ".ud"}, 32'(bus.UD), 32'(ud_m));
    chk_eq({t, ".d"},  32'(bus.D),  32'(d_m));
  endtask

  initial begin
    RST        = 1'b1;
    bus.BTN_UP = 1'b0;
    bus.BTN_DN = 1'b0;
    bus.BTN_LD = 1'b0;
    bus.SW     = 4'h0;
    ud_m       = 1'b1;
    d_m        = 4'h0;
    exp_ce     = 1'b0;
    exp_ld     = 1'b0;
    repeat (3) step();
    chk_outs("reset", 0);
    RST = 1'b0;

    // Single UP press, released before the repeat delay.
    bus.BTN_UP = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      exp_ce = (e == 7);
      exp_ld = 1'b0;
      if (exp_ce) ud_m = 1'b1;
      chk_outs("up_single", e);
      if (e == 10) bus.BTN_UP = 1'b0;
    end

    // Three-cycle glitch must never debounce.
    bus.BTN_UP = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      exp_ce = 1'b0;
      exp_ld = 1'b0;
      chk_outs("glitch", e);
      chk_eq($sformatf("glitch_lvl@%0d", e), 32'(dut.btn_lvl_r[0]), 32'd0);
      if (e == 3) bus.BTN_UP = 1'b0;
    end

    // DN held: press, then +20, then every 5 until the level falls at edge 74.
    bus.BTN_DN = 1'b1;
    for (int e = 1; e <= 90; e++) begin
      step();
      exp_ce = (e == 7) || (e >= 27 && e <= 74 && ((e - 27) % 5) == 0);
      exp_ld = 1'b0;
      if (exp_ce) ud_m = 1'b0;
      chk_outs("dn_rpt", e);
      if (e == 67) bus.BTN_DN = 1'b0;
    end

    // LD held: one load of 4'hA, UD keeps 0, no repeat.
    bus.SW     = 4'hA;
    bus.BTN_LD = 1'b1;
    for (int e = 1; e <= 110; e++) begin
      step();
      exp_ce = (e == 7);
      exp_ld = exp_ce;
      if (exp_ce) d_m = 4'hA;
      chk_outs("ld_hold", e);
      if (e == 100) bus.BTN_LD = 1'b0;
    end

    // LD and UP together: LD wins, UP discarded, no repeat afterwards.
    bus.SW     = 4'h5;
    bus.BTN_LD = 1'b1;
    bus.BTN_UP = 1'b1;
    for (int e = 1; e <= 55; e++) begin
      step();
      exp_ce = (e == 7);
      exp_ld = exp_ce;
      if (exp_ce) d_m = 4'h5;
      chk_outs("ld_up", e);
      if (e == 40) begin
        bus.BTN_LD = 1'b0;
        bus.BTN_UP = 1'b0;
      end
    end

    // UP then DN one cycle apart: two consecutive CE cycles.
    bus.BTN_UP = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      step();
      exp_ce = (e == 7) || (e == 8);
      exp_ld = 1'b0;
      if (e == 7) ud_m = 1'b1;
      if (e == 8) ud_m = 1'b0;
      chk_outs("b2b", e);
      if (e == 1) bus.BTN_DN = 1'b1;
      if (e == 10) begin
        bus.BTN_UP = 1'b0;
        bus.BTN_DN = 1'b0;
      end
    end

    // Reset pulse during RPT with UP held, then a fresh press.
    bus.BTN_UP = 1'b1;
    for (int e = 1; e <= 65; e++) begin
      step();
      exp_ce = (e == 7) || (e == 27) || (e == 37);
      exp_ld = 1'b0;
      if (exp_ce) ud_m = 1'b1;
      if (e == 30) begin
        ud_m = 1'b1;
        d_m  = 4'h0;
      end
      chk_outs("rst_rpt", e);
      if (e == 29) RST = 1'b1;
      if (e == 30) RST = 1'b0;
      if (e == 45) bus.BTN_UP = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
